// File: rtl/riscv_pkg.sv
// Shared trace types and helpers used by the commit trace buffer and its FIFO.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;

   typedef enum logic [2:0] {
      TK_NOP   = 3'd0,
      TK_REG   = 3'd1,
      TK_LOAD  = 3'd2,
      TK_STORE = 3'd3,
      TK_STALL = 3'd4,
      TK_FLUSH = 3'd5
   } trace_kind_e;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_ARMED   = 2'd1,
      CAP_CAPTURE = 2'd2,
      CAP_DONE    = 2'd3
   } cap_state_e;

   typedef struct packed {
      trace_kind_e     kind;
      logic            lost;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] addr;
   } trace_rec_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Store data is only meaningful up to the access width encoded in funct3.
   function automatic logic [XLEN-1:0] store_data(input logic [XLEN-1:0] d,
                                                  input logic [2:0]      funct3);
      case (funct3)
         3'b000:  return {{(XLEN-8){1'b0}}, d[7:0]};
         3'b001:  return {{(XLEN-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic FIFO for trace records; head is visible combinationally from the
// storage registers, and reads as zero while empty.
module trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter type         rec_t = logic [31:0]
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  rec_t push_rec_i,
   input  logic pop_i,
   output rec_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   rec_t        mem_q [DEPTH];
   logic        wr_en;
   logic        rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are
   // valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_rec_i;
   end

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// Classifies retiring commit slots into trace records, buffers them and keeps
// capture counters. Define TRACE_FILTER_HAZARD_EN to keep STALL/FLUSH out of the FIFO.
module commit_trace_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned MAX_REC = 1024
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            arm_i,
   input  logic            stop_i,
   input  logic [XLEN-1:0] trig_pc_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [4:0]      reg_addr_i,
   input  logic [XLEN-1:0] reg_data_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic            stall_i,
   input  logic            flushD_i,
   input  logic            flushE_i,
   output logic            rec_valid_o,
   input  logic            rec_ready_i,
   output trace_rec_t      rec_o,
   output logic [1:0]      state_o,
   output logic [31:0]     cnt_rec_o,
   output logic [31:0]     cnt_stall_o,
   output logic [31:0]     cnt_flush_o,
   output logic [31:0]     cnt_drop_o,
   output logic            overflow_o
);

   localparam logic [31:0] REC_LAST = 32'(MAX_REC - 1);

   cap_state_e  state_q, state_d;
   trace_rec_t  sample;
   logic [31:0] cnt_rec_q, cnt_stall_q, cnt_flush_q, cnt_drop_q;
   logic        overflow_q, lost_q;
   logic        capture, push_en, push_req, push_ok, drop, pop, full, empty;
   logic        rearm, max_hit;

   // NOTE: every field gets a default before the priority chain, so no path
   // through this block leaves a value to be held in a latch.
   always_comb begin
      sample       = '0;
      sample.pc    = pc_i;
      sample.instr = instr_i;
      sample.lost  = lost_q;
      if (instr_i[6:0] == OPC_STORE) begin
         sample.kind = TK_STORE;
         sample.data = store_data(mem_data_i, instr_i[14:12]);
         sample.addr = mem_addr_i;
      end else if (instr_i[6:0] == OPC_LOAD) begin
         sample.kind = TK_LOAD;
         sample.rd   = reg_addr_i;
         sample.data = reg_data_i;
         sample.addr = mem_addr_i;
      end else if (stall_i || flushD_i || flushE_i || reg_addr_i != 5'd0) begin
         sample.kind = stall_i ? TK_STALL :
                       (flushD_i || flushE_i) ? TK_FLUSH : TK_REG;
         sample.rd   = reg_addr_i;
         sample.data = reg_data_i;
      end
   end

`ifdef TRACE_FILTER_HAZARD_EN
   assign push_en = (sample.kind != TK_STALL) && (sample.kind != TK_FLUSH);
`else
   assign push_en = 1'b1;
`endif

   // stop_i wins over both the trigger match and the push of this cycle.
   assign capture  = !stop_i && ((state_q == CAP_CAPTURE) ||
                                 (state_q == CAP_ARMED && pc_i == trig_pc_i));
   assign pop      = rec_valid_o && rec_ready_i;
   assign push_req = capture && push_en;
   assign push_ok  = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign rearm    = (state_q == CAP_DONE) && arm_i;
   assign max_hit  = (MAX_REC != 0) && (cnt_rec_q == REC_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         CAP_IDLE:    if (arm_i) state_d = CAP_ARMED;
         CAP_ARMED:   if (stop_i) state_d = CAP_DONE;
                      else if (pc_i == trig_pc_i) state_d = CAP_CAPTURE;
         CAP_CAPTURE: if (stop_i) state_d = CAP_DONE;
         CAP_DONE:    if (arm_i) state_d = CAP_ARMED;
         default:     state_d = CAP_IDLE;
      endcase
      if (push_ok && max_hit) state_d = CAP_DONE;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= CAP_IDLE;
         cnt_rec_q   <= '0;
         cnt_stall_q <= '0;
         cnt_flush_q <= '0;
         cnt_drop_q  <= '0;
         overflow_q  <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rearm)        cnt_rec_q <= '0;
         else if (push_ok) cnt_rec_q <= sat_inc(cnt_rec_q);
         if (capture && sample.kind == TK_STALL) cnt_stall_q <= sat_inc(cnt_stall_q);
         if (capture && sample.kind == TK_FLUSH) cnt_flush_q <= sat_inc(cnt_flush_q);
         if (drop) cnt_drop_q <= sat_inc(cnt_drop_q);
         if (rearm)     overflow_q <= 1'b0;
         else if (drop) overflow_q <= 1'b1;
         if (drop)         lost_q <= 1'b1;
         else if (push_ok) lost_q <= 1'b0;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .rec_t (trace_rec_t)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push_ok),
      .push_rec_i (sample),
      .pop_i      (pop),
      .head_o     (rec_o),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign rec_valid_o = !empty;
   assign state_o     = state_q;
   assign cnt_rec_o   = cnt_rec_q;
   assign cnt_stall_o = cnt_stall_q;
   assign cnt_flush_o = cnt_flush_q;
   assign cnt_drop_o  = cnt_drop_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer (DEPTH=4, MAX_REC=8).
module tb_commit_trace_buffer;
   import riscv_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned MAX_REC = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        arm_i = 1'b0, stop_i = 1'b0;
   logic [31:0] trig_pc_i = '0, pc_i = '0, instr_i = 32'h13;
   logic [4:0]  reg_addr_i = '0;
   logic [31:0] reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
   logic        stall_i = 1'b0, flushD_i = 1'b0, flushE_i = 1'b0;
   logic        rec_valid_o, rec_ready_i = 1'b0;
   trace_rec_t  rec_o;
   logic [1:0]  state_o;
   logic [31:0] cnt_rec_o, cnt_stall_o, cnt_flush_o, cnt_drop_o;
   logic        overflow_o;

   int         checks   = 0;
   int         failures = 0;
   int         n_popped = 0;
   trace_rec_t exp_q[$];

   always #5 clk_i = ~clk_i;

   commit_trace_buffer #(.DEPTH(DEPTH), .MAX_REC(MAX_REC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .stop_i(stop_i),
      .trig_pc_i(trig_pc_i), .pc_i(pc_i), .instr_i(instr_i),
      .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .stall_i(stall_i), .flushD_i(flushD_i), .flushE_i(flushE_i),
      .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_o(rec_o),
      .state_o(state_o), .cnt_rec_o(cnt_rec_o), .cnt_stall_o(cnt_stall_o),
      .cnt_flush_o(cnt_flush_o), .cnt_drop_o(cnt_drop_o), .overflow_o(overflow_o)
   );

   function automatic trace_rec_t mk(input trace_kind_e k, input logic lost,
                                     input logic [4:0] rd, input logic [31:0] pc,
                                     input logic [31:0] instr, input logic [31:0] data,
                                     input logic [31:0] addr);
      trace_rec_t r;
      r.kind = k; r.lost = lost; r.rd = rd; r.pc = pc;
      r.instr = instr; r.data = data; r.addr = addr;
      return r;
   endfunction

   task automatic set_in(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] maddr, input logic [31:0] mdata,
                         input logic stall, input logic fd, input logic fe);
      pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = rdata;
      mem_addr_i = maddr; mem_data_i = mdata;
      stall_i = stall; flushD_i = fd; flushE_i = fe;
   endtask

   // Called at a negedge: scores a pop due on the coming edge, then advances.
   task automatic cycle();
      trace_rec_t e;
      if (rec_valid_o && rec_ready_i) begin
         checks++;
         n_popped++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rec_unexpected got=%h", rec_o);
         end else begin
            e = exp_q.pop_front();
            if (rec_o !== e) begin
               failures++;
               $display("FAIL rec_data got=%h exp=%h", rec_o, e);
            end
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
      arm_i  = 1'b0;
      stop_i = 1'b0;
   endtask

   task automatic drain();
      rec_ready_i = 1'b1;
      set_in(32'h0, 32'h13, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
      cycle();
      cycle();
      rec_ready_i = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_left got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      arm_i = 1'b0; stop_i = 1'b0; rec_ready_i = 1'b0;
      set_in(32'h0, 32'h13, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic start(input logic [31:0] trig);
      do_reset();
      trig_pc_i = trig;
      arm_i = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      #1;
      checks++; if (state_o !== CAP_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_o); end
      checks++; if (rec_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rec_valid_o); end
      checks++; if (rec_o !== '0) begin failures++; $display("FAIL rst_rec got=%h exp=0", rec_o); end
      checks++; if ({cnt_rec_o, cnt_stall_o, cnt_flush_o, cnt_drop_o} !== 128'h0) begin
         failures++; $display("FAIL rst_counters got=%h exp=0", {cnt_rec_o, cnt_stall_o, cnt_flush_o, cnt_drop_o}); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
      do_reset();
   endtask

   task automatic test_trigger();
      start(32'h8000_0010);
      checks++; if (state_o !== CAP_ARMED) begin failures++; $display("FAIL trig_armed got=%0d exp=1", state_o); end
      set_in(32'h8000_000C, 32'h0010_0093, 5'd1, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++; if (state_o !== CAP_ARMED || rec_valid_o !== 1'b0) begin
         failures++; $display("FAIL trig_early got=%0d/%b exp=1/0", state_o, rec_valid_o); end
      set_in(32'h8000_0010, 32'h0020_0113, 5'd2, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_REG, 1'b0, 5'd2, 32'h8000_0010, 32'h0020_0113, 32'h2, 32'h0));
      cycle();
      checks++; if (state_o !== CAP_CAPTURE) begin failures++; $display("FAIL trig_capture got=%0d exp=2", state_o); end
      set_in(32'h8000_0014, 32'h0030_0193, 5'd3, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_REG, 1'b0, 5'd3, 32'h8000_0014, 32'h0030_0193, 32'h3, 32'h0));
      cycle();
      checks++; if (rec_valid_o !== 1'b1 || rec_o.pc !== 32'h8000_0010) begin
         failures++; $display("FAIL trig_first_pc got=%b/%h exp=1/80000010", rec_valid_o, rec_o.pc); end
      stop_i = 1'b1;
      set_in(32'h8000_0018, 32'h0040_0213, 5'd4, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++; if (state_o !== CAP_DONE) begin failures++; $display("FAIL trig_stop got=%0d exp=3", state_o); end
      drain();
   endtask

   task automatic test_store_load();
      start(32'h1000);
      rec_ready_i = 1'b1;
      set_in(32'h1000, 32'h00B5_0023, 5'd7, 32'h9, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_STORE, 1'b0, 5'd0, 32'h1000, 32'h00B5_0023, 32'h0000_00EF, 32'h100));
      cycle();
      set_in(32'h1004, 32'h00B5_1023, 5'd0, 32'h0, 32'h104, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_STORE, 1'b0, 5'd0, 32'h1004, 32'h00B5_1023, 32'h0000_BEEF, 32'h104));
      cycle();
      set_in(32'h1008, 32'h00B5_2023, 5'd0, 32'h0, 32'h108, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_STORE, 1'b0, 5'd0, 32'h1008, 32'h00B5_2023, 32'hDEAD_BEEF, 32'h108));
      cycle();
      set_in(32'h100C, 32'h0005_2583, 5'd11, 32'hCAFE_F00D, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_LOAD, 1'b0, 5'd11, 32'h100C, 32'h0005_2583, 32'hCAFE_F00D, 32'h200));
      cycle();
      set_in(32'h1010, 32'h0000_0013, 5'd0, 32'h55, 32'h77, 32'h66, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_NOP, 1'b0, 5'd0, 32'h1010, 32'h0000_0013, 32'h0, 32'h0));
      cycle();
      stop_i = 1'b1;
      cycle();
      drain();
   endtask

   task automatic test_overflow();
      int n0;
      start(32'h2000);
      for (int i = 0; i < 6; i++) begin
         set_in(32'h2000 + 32'(4 * i), 32'h0010_0093, 5'd1, 32'(i), 32'h9, 32'h0, 1'b0, 1'b0, 1'b0);
         if (i < 4) exp_q.push_back(mk(TK_REG, 1'b0, 5'd1, 32'h2000 + 32'(4 * i), 32'h0010_0093, 32'(i), 32'h0));
         cycle();
      end
      checks++; if (cnt_drop_o !== 32'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", cnt_drop_o); end
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
      checks++; if (cnt_rec_o !== 32'd4) begin failures++; $display("FAIL ovf_rec got=%0d exp=4", cnt_rec_o); end
      rec_ready_i = 1'b1;
      for (int i = 6; i < 8; i++) begin
         set_in(32'h2000 + 32'(4 * i), 32'h0010_0093, 5'd1, 32'(i), 32'h9, 32'h0, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(mk(TK_REG, i == 6, 5'd1, 32'h2000 + 32'(4 * i), 32'h0010_0093, 32'(i), 32'h0));
         cycle();
      end
      checks++; if (cnt_drop_o !== 32'd2 || cnt_rec_o !== 32'd6) begin
         failures++; $display("FAIL ovf_push_pop got=%0d/%0d exp=2/6", cnt_drop_o, cnt_rec_o); end
      rec_ready_i = 1'b0;
      stop_i = 1'b1;
      cycle();
      n0 = n_popped;
      drain();
      checks++; if (n_popped - n0 != 4) begin failures++; $display("FAIL ovf_occupancy got=%0d exp=4", n_popped - n0); end
   endtask

   task automatic test_stall();
      start(32'h3000);
      rec_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(32'h3000 + 32'(4 * i), 32'h0050_0293, 5'd5, 32'h100 + 32'(i), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
`ifndef TRACE_FILTER_HAZARD_EN
         exp_q.push_back(mk(TK_STALL, 1'b0, 5'd5, 32'h3000 + 32'(4 * i), 32'h0050_0293, 32'h100 + 32'(i), 32'h0));
`endif
         cycle();
      end
      set_in(32'h300C, 32'h0050_0293, 5'd5, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
`ifndef TRACE_FILTER_HAZARD_EN
      exp_q.push_back(mk(TK_FLUSH, 1'b0, 5'd5, 32'h300C, 32'h0050_0293, 32'h200, 32'h0));
`endif
      cycle();
      set_in(32'h3010, 32'h0050_0293, 5'd5, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(TK_REG, 1'b0, 5'd5, 32'h3010, 32'h0050_0293, 32'h300, 32'h0));
      cycle();
      stop_i = 1'b1;
      cycle();
      checks++; if (cnt_stall_o !== 32'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", cnt_stall_o); end
      checks++; if (cnt_flush_o !== 32'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", cnt_flush_o); end
      checks++; if (cnt_drop_o !== 32'd0) begin failures++; $display("FAIL stall_drop got=%0d exp=0", cnt_drop_o); end
`ifdef TRACE_FILTER_HAZARD_EN
      checks++; if (cnt_rec_o !== 32'd1) begin failures++; $display("FAIL stall_rec got=%0d exp=1", cnt_rec_o); end
`else
      checks++; if (cnt_rec_o !== 32'd5) begin failures++; $display("FAIL stall_rec got=%0d exp=5", cnt_rec_o); end
`endif
      drain();
   endtask

   task automatic test_max_rec();
      start(32'h4000);
      rec_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(32'h4000 + 32'(4 * i), 32'h0020_0113, 5'd2, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
         if (i < 8) exp_q.push_back(mk(TK_REG, 1'b0, 5'd2, 32'h4000 + 32'(4 * i), 32'h0020_0113, 32'(i), 32'h0));
         cycle();
         if (i == 6) begin
            checks++; if (state_o !== CAP_CAPTURE) begin failures++; $display("FAIL max_before got=%0d exp=2", state_o); end
         end
         if (i == 7 || i == 9) begin
            checks++; if (state_o !== CAP_DONE) begin failures++; $display("FAIL max_done got=%0d exp=3", state_o); end
         end
      end
      checks++; if (cnt_rec_o !== 32'd8) begin failures++; $display("FAIL max_rec got=%0d exp=8", cnt_rec_o); end
      drain();
      arm_i = 1'b1;
      cycle();
      checks++; if (state_o !== CAP_ARMED || cnt_rec_o !== 32'd0) begin
         failures++; $display("FAIL rearm got=%0d/%0d exp=1/0", state_o, cnt_rec_o); end
   endtask

   task automatic test_reset_mid();
      start(32'h5000);
      for (int i = 0; i < 3; i++) begin
         set_in(32'h5000 + 32'(4 * i), 32'h0030_0193, 5'd3, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      checks++; if (cnt_rec_o !== 32'd3 || rec_valid_o !== 1'b1) begin
         failures++; $display("FAIL mid_setup got=%0d/%b exp=3/1", cnt_rec_o, rec_valid_o); end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (rec_valid_o !== 1'b0 || state_o !== CAP_IDLE || rec_o !== '0) begin
         failures++; $display("FAIL mid_rst_out got=%b/%0d/%h exp=0/0/0", rec_valid_o, state_o, rec_o); end
      checks++; if ({cnt_rec_o, cnt_stall_o, cnt_flush_o, cnt_drop_o, 31'h0, overflow_o} !== 160'h0) begin
         failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", cnt_rec_o); end
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_trigger();
      test_store_load();
      test_overflow();
      test_stall();
      test_max_rec();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
